// File: rtl/nou_retire_arb.sv
// nou_retire_arb: in-order retire arbiter for the NOU response path.
// Collects SID-tagged responses from NUM_UNIT retire units and untagged RPU
// responses. Unit responses retire strictly in SID order, and the RPU fills
// idle slots or is forced through after RPU_MAX_WAIT pass-overs. Writes go to
// the RV response FIFO through a registered stage under credit flow control.
// Optional feature macro: NOU_RETIRE_SID_CHK_EN builds the sticky sid_err
// checker (duplicate valid SIDs, or a pop while all credits are held).
module nou_retire_arb #(
   parameter int NUM_UNIT     = 4,
   parameter int SID_WIDTH    = 4,
   parameter int DATA_WIDTH   = 64,
   parameter int FIFO_DEPTH   = 8,
   parameter int RPU_MAX_WAIT = 8
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic [NUM_UNIT-1:0]              unit_vld,
   input  logic [NUM_UNIT*SID_WIDTH-1:0]    unit_sid,
   input  logic [NUM_UNIT*DATA_WIDTH-1:0]   unit_data,
   output logic [NUM_UNIT-1:0]              unit_keep,
   input  logic                             rpu_rsp_vld,
   input  logic [DATA_WIDTH-1:0]            rpu_rsp_data,
   output logic                             rpu_rsp_gnt,
   input  logic                             rsp_fifo_rd,
   output logic                             rsp_fifo_wr_en,
   output logic [DATA_WIDTH-1:0]            rsp_fifo_data,
   output logic [NUM_UNIT:0]                retire_uov,
   output logic [SID_WIDTH-1:0]             next_sid,
   output logic                             sid_err
);

   localparam int CREDIT_W = $clog2(FIFO_DEPTH + 1);
   localparam int WAIT_W   = $clog2(RPU_MAX_WAIT + 1);
   localparam int IDX_W    = (NUM_UNIT > 1) ? $clog2(NUM_UNIT) : 1;
   localparam logic [CREDIT_W-1:0] CREDIT_MAX = CREDIT_W'(FIFO_DEPTH);
   localparam logic [WAIT_W-1:0]   WAIT_MAX   = WAIT_W'(RPU_MAX_WAIT);

   logic [CREDIT_W-1:0]   credit;
   logic [WAIT_W-1:0]     rpu_wait;
   logic [NUM_UNIT-1:0]   unit_match;
   logic [NUM_UNIT-1:0]   unit_grant;
   logic [IDX_W-1:0]      sel_idx;
   logic                  any_match;
   logic                  has_credit;
   logic                  rpu_force;
   logic                  rpu_grant;
   logic                  unit_grant_any;
   logic                  any_grant;
   logic                  pop_ok;
   logic [DATA_WIDTH-1:0] grant_data;

   // A unit is eligible only when it holds exactly the SID due next
   always_comb begin
      unit_match = '0;
      for (int i = 0; i < NUM_UNIT; i++) begin
         unit_match[i] = unit_vld[i] && (unit_sid[i*SID_WIDTH +: SID_WIDTH] == next_sid);
      end
   end

   // Lowest-index eligible unit wins when several present the same SID
   always_comb begin
      sel_idx = '0;
      for (int i = NUM_UNIT - 1; i >= 0; i--) begin
         if (unit_match[i]) begin
            sel_idx = IDX_W'(i);
         end
      end
   end

   assign any_match  = |unit_match;
   assign has_credit = (credit != '0);
   assign rpu_force  = rpu_rsp_vld && (rpu_wait == WAIT_MAX);
   assign pop_ok     = rsp_fifo_rd && (credit != CREDIT_MAX);

   // Grants are gated by rst_n so the combinational outputs read 0 during reset
   assign rpu_grant      = rst_n && has_credit && rpu_rsp_vld && (rpu_force || !any_match);
   assign unit_grant_any = rst_n && has_credit && any_match && !rpu_force;
   assign any_grant      = rpu_grant || unit_grant_any;

   // One-hot unit grant vector drives both the keep outputs and retire_uov
   always_comb begin
      unit_grant = '0;
      if (unit_grant_any) begin
         unit_grant[sel_idx] = 1'b1;
      end
   end

   assign grant_data  = rpu_grant ? rpu_rsp_data : unit_data[sel_idx*DATA_WIDTH +: DATA_WIDTH];
   assign unit_keep   = unit_vld & ~unit_grant & {NUM_UNIT{rst_n}};
   assign rpu_rsp_gnt = rpu_grant;

   // Arbitration state: expected SID, RPU starvation counter and FIFO credits
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         next_sid <= '0;
         rpu_wait <= '0;
         credit   <= CREDIT_MAX;
      end else begin
         if (unit_grant_any) begin
            next_sid <= next_sid + SID_WIDTH'(1);
         end
         if (rpu_grant) begin
            rpu_wait <= '0;
         end else if (rpu_rsp_vld && (rpu_wait != WAIT_MAX)) begin
            rpu_wait <= rpu_wait + WAIT_W'(1);
         end
         if (any_grant && !pop_ok) begin
            credit <= credit - CREDIT_W'(1);
         end else if (!any_grant && pop_ok) begin
            credit <= credit + CREDIT_W'(1);
         end
      end
   end

   // Registered write stage: one FIFO write per grant, one cycle later
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_fifo_wr_en <= 1'b0;
         rsp_fifo_data  <= '0;
         retire_uov     <= '0;
      end else begin
         rsp_fifo_wr_en <= any_grant;
         retire_uov     <= {rpu_grant, unit_grant};
         if (any_grant) begin
            rsp_fifo_data <= grant_data;
         end
      end
   end

`ifdef NOU_RETIRE_SID_CHK_EN
   logic dup_sid;

   // Flag any pair of valid units presenting the same SID
   always_comb begin
      dup_sid = 1'b0;
      for (int i = 0; i < NUM_UNIT; i++) begin
         for (int j = i + 1; j < NUM_UNIT; j++) begin
            if (unit_vld[i] && unit_vld[j] &&
                (unit_sid[i*SID_WIDTH +: SID_WIDTH] == unit_sid[j*SID_WIDTH +: SID_WIDTH])) begin
               dup_sid = 1'b1;
            end
         end
      end
   end

   // Sticky error: duplicate SIDs or a pop with every credit already returned
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sid_err <= 1'b0;
      end else if (dup_sid || (rsp_fifo_rd && (credit == CREDIT_MAX))) begin
         sid_err <= 1'b1;
      end
   end
`else
   assign sid_err = 1'b0;
`endif

endmodule

// File: doc/nou_retire_arb.md
# nou_retire_arb

Parametrised in-order retire arbiter for the NOU response path. It collects pre-formatted responses from `NUM_UNIT` retire units, each tagged with a SID, plus untagged RPU packet responses. Unit responses are written in strict SID order, and RPU responses fill idle slots or win after a bounded wait. Writes go into the RV response FIFO through a registered output stage with credit-based flow control, and the block reports the granted source to the decode stage.

## Interface
Parameters:
- `NUM_UNIT`, 4: number of SID-tagged retire units, 2..8.
- `SID_WIDTH`, 4: SID width; SIDs wrap modulo 2^SID_WIDTH.
- `DATA_WIDTH`, 64: response word width (XOCC command width).
- `FIFO_DEPTH`, 8: RV response FIFO entries; initial credit count.
- `RPU_MAX_WAIT`, 8: cycles an RPU response may be passed over before it is forced; must be >= 1.

Ports (clock and reset listed first):
- `clk`, in, 1: clock.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `unit_vld`, in, NUM_UNIT: unit i holds a response.
- `unit_sid`, in, NUM_UNIT*SID_WIDTH: SID of unit i, stored at slice i.
- `unit_data`, in, NUM_UNIT*DATA_WIDTH: formatted response of unit i.
- `unit_keep`, out, NUM_UNIT: unit i must hold its response next cycle.
- `rpu_rsp_vld`, in, 1: RPU packet response pending.
- `rpu_rsp_data`, in, DATA_WIDTH: RPU response word.
- `rpu_rsp_gnt`, out, 1: RPU response consumed this cycle.
- `rsp_fifo_rd`, in, 1: one-cycle pulse when the consumer pops one FIFO entry.
- `rsp_fifo_wr_en`, out, 1: registered FIFO write strobe.
- `rsp_fifo_data`, out, DATA_WIDTH: registered FIFO write data.
- `retire_uov`, out, NUM_UNIT+1: registered one-hot of the last granted source. Bit NUM_UNIT is the RPU.
- `next_sid`, out, SID_WIDTH: SID expected next.
- `sid_err`, out, 1: sticky SID error flag (see Configuration).

## Operation
- **Unit match:** unit i matches when `unit_vld[i]` is high and `unit_sid[i] == next_sid`. If several units match, the lowest index is taken.
- **Grant conditions:** a grant occurs only when `credit > 0`. At most one grant per cycle.
- **Priority:**
  - If `rpu_wait == RPU_MAX_WAIT` and `rpu_rsp_vld` is high, the RPU is granted.
  - Otherwise a matching unit is granted.
  - Otherwise a pending RPU response is granted.
  - Otherwise there is no grant.
- **Unit grant:** `next_sid <= next_sid + 1`, wrapping from 2^SID_WIDTH-1 to 0.
- **RPU grant:** `rpu_wait` clears to 0.
- **RPU passed over:** when `rpu_rsp_vld` is high and the RPU is not granted for any reason, `rpu_wait` increments and saturates at RPU_MAX_WAIT.
- **Keep and grant outputs** (combinational):
  - `unit_keep[i] = unit_vld[i] & ~grant[i]`.
  - `rpu_rsp_gnt` = RPU grant.
- **Credits:** `credit` counter is $clog2(FIFO_DEPTH+1) bits wide.
  - Decrements on grant, increments on `rsp_fifo_rd`.
  - Grant and pop in the same cycle leave it unchanged.
  - It never exceeds FIFO_DEPTH. A pop at FIFO_DEPTH is a protocol violation and is ignored.
- **Non-matching units** are held indefinitely. The block waits for the unit holding `next_sid`.

## Timing
- Grant decision is combinational in cycle N.
- `rsp_fifo_wr_en`, `rsp_fifo_data` and `retire_uov` are registered and appear in cycle N+1. Write-back latency is 1.
- `rsp_fifo_wr_en` is high for exactly one cycle per grant. Back-to-back grants give back-to-back writes; throughput is 1 per cycle while credits last.
- `retire_uov` holds the grant vector for one cycle and is 0 otherwise.
- Reset values:
  - `next_sid` = 0.
  - `credit` = FIFO_DEPTH.
  - `rpu_wait` = 0.
  - `rsp_fifo_wr_en` = 0, `rsp_fifo_data` = 0, `retire_uov` = 0.
  - `sid_err` = 0.
- Combinational outputs (`unit_keep`, `rpu_rsp_gnt`) follow their inputs; while reset is asserted they are forced to 0.
- Reset mid-operation discards the registered write in flight. Upstream and the FIFO are reset in the same domain.
- Credit exhaustion: with `credit == 0` there is no grant, all `unit_keep` follow `unit_vld`, and `rpu_wait` still counts.

## Configuration
- Macro `NOU_RETIRE_SID_CHK_EN`.
- **Defined:** `sid_err` sets, and stays set until reset, when in any cycle either:
  - two or more valid units present the same SID; or
  - `rsp_fifo_rd` arrives with `credit == FIFO_DEPTH`.
  
  Arbitration is unaffected; the lowest index still wins.
- **Undefined:** no checking logic is built and `sid_err` is tied to 0.

## Test plan
- **Out-of-order presentation:** units 0..3 valid with SIDs 3,1,0,2 at reset. Expect 4 writes in cycles 1..4 carrying unit 2,1,3,0 data; `retire_uov` = 00100, 00010, 01000, 00001; `next_sid` ends at 4.
- **SID wrap:** SID_WIDTH=4. Retire SIDs 14,15,0 consecutively. Expect `next_sid` 15→0→1 with no stall.
- **Credit exhaustion:** FIFO_DEPTH=8, no pops. Expect exactly 8 writes, then `unit_keep` stays high. One `rsp_fifo_rd` pulse yields exactly one more write, one cycle after the grant.
- **RPU starvation:** `rpu_rsp_vld` held while units continuously match. Expect `rpu_rsp_gnt` on the 9th cycle (`rpu_wait` reaches 8), writing RPU data with `retire_uov` bit 4 set. Unit retirement then resumes with the same `next_sid`.
- **Reset mid-operation:** assert `rst_n` low while a write is pending. Expect `rsp_fifo_wr_en` = 0 immediately, `credit` = 8, `next_sid` = 0.
- **Check macro:** units 0 and 1 both valid with SID 0. With `NOU_RETIRE_SID_CHK_EN` defined, `sid_err` rises and unit 0 is granted. Without the macro, `sid_err` stays 0.
